// File: rtl/minx_rtc_pkg.sv
// rtl/minx_rtc_pkg.sv - shared register map constants and FSM type for the minx RTC responder
package minx_rtc_pkg;

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_CNT_L = 2'd1;
   localparam logic [1:0] REG_CNT_M = 2'd2;
   localparam logic [1:0] REG_CNT_H = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_CLR = 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ACK} rtc_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for toggle-style handshake signals
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/minx_rtc_responder.sv
// rtl/minx_rtc_responder.sv - clk_rt side of the CPU-bus crossing; owns the seconds counter and its registers
module minx_rtc_responder
   import minx_rtc_pkg::*;
#(
   parameter int          TICKS_PER_SEC = 32768,
   parameter logic [23:0] ADDR_BASE     = 24'h2008
) (
   input  logic        clk_rt,
   input  logic        reset,
   input  logic        rt_ce,
   input  logic        req_toggle,
   input  logic        req_write,
   input  logic [23:0] req_address,
   input  logic [7:0]  req_wdata,
   output logic        ack_toggle,
   output logic [7:0]  rdata,
   output logic [23:0] sec_count,
   output logic        sec_tick
);

   localparam logic [14:0] PRE_MAX = 15'(TICKS_PER_SEC - 1);

   rtc_state_t  state;
   logic        req_sync;
   logic        pending;
   logic        lat_write;
   logic [23:0] lat_addr;
   logic [7:0]  lat_wdata;
   logic [23:0] offset;
   logic        in_window;
   logic [1:0]  reg_sel;
   logic        do_clear;
   logic        enable;
   logic [14:0] prescaler;
   logic [23:0] seconds;
   logic [15:0] shadow;
   logic        unused_wdata;

   sync_2ff #(.WIDTH(1)) u_req_sync (
      .clk   (clk_rt),
      .reset (reset),
      .d     (req_toggle),
      .q     (req_sync)
   );

   assign pending      = req_sync ^ ack_toggle;
   assign offset       = lat_addr - ADDR_BASE;
   assign in_window    = (offset[23:2] == 22'd0);
   assign reg_sel      = offset[1:0];
   assign sec_count    = seconds;
   assign unused_wdata = ^lat_wdata[7:2];

   // Clear is evaluated here so the counter block can give it priority over a same-cycle wrap.
   assign do_clear = (state == S_EXEC) && lat_write && in_window &&
                     (reg_sel == REG_CTRL) && lat_wdata[CTRL_CLR];

   always_ff @(posedge clk_rt or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ack_toggle <= 1'b0;
         rdata      <= 8'h00;
         lat_write  <= 1'b0;
         lat_addr   <= 24'h000000;
         lat_wdata  <= 8'h00;
         enable     <= 1'b0;
         shadow     <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (pending) begin
                  lat_write <= req_write;
                  lat_addr  <= req_address;
                  lat_wdata <= req_wdata;
                  state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               rdata <= 8'h00;
               if (in_window) begin
                  if (lat_write) begin
                     if (reg_sel == REG_CTRL)
                        enable <= lat_wdata[CTRL_EN];
                  end else begin
                     case (reg_sel)
                        REG_CTRL:  rdata <= {7'd0, enable};
                        REG_CNT_L: begin
                           rdata  <= seconds[7:0];
                           shadow <= seconds[23:8];
                        end
                        REG_CNT_M: rdata <= shadow[7:0];
                        default:   rdata <= shadow[15:8];
                     endcase
                  end
               end
               state <= S_ACK;
            end
            S_ACK: begin
               ack_toggle <= ~ack_toggle;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_rt or posedge reset) begin
      if (reset) begin
         prescaler <= 15'd0;
         seconds   <= 24'h000000;
         sec_tick  <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         if (do_clear) begin
            prescaler <= 15'd0;
            seconds   <= 24'h000000;
         end else if (enable && rt_ce) begin
            if (prescaler == PRE_MAX) begin
               prescaler <= 15'd0;
               seconds   <= seconds + 24'd1;
               sec_tick  <= 1'b1;
            end else begin
               prescaler <= prescaler + 15'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_minx_rtc_responder.sv
// tb/tb_minx_rtc_responder.sv - self-checking bench for minx_rtc_responder with a transaction-level model
module tb_minx_rtc_responder;
   import minx_rtc_pkg::*;

   localparam int          TICKS = 4;
   localparam logic [23:0] BASE  = 24'h2008;

   logic        clk_rt      = 1'b0;
   logic        reset       = 1'b1;
   logic        rt_ce       = 1'b1;
   logic        req_toggle  = 1'b0;
   logic        req_write   = 1'b0;
   logic [23:0] req_address = 24'h0;
   logic [7:0]  req_wdata   = 8'h0;
   logic        ack_toggle;
   logic [7:0]  rdata;
   logic [23:0] sec_count;
   logic        sec_tick;

   int errors = 0;
   int checks = 0;
   logic run_cmp = 1'b0;
   logic exp_ack = 1'b0;

   // request log written by stimulus, consumed by the model
   int          op_exec [0:63];
   logic        op_w    [0:63];
   logic [23:0] op_a    [0:63];
   logic [7:0]  op_d    [0:63];
   int          n_issued = 0;
   int          f_seq = 0;
   logic [23:0] f_cnt = 24'h0;
   int          f_pre = 0;

   // model state
   int          edge_count = 0;
   int          op_idx = 0;
   int          f_seen = 0;
   int          ack_edges[$];
   logic        m_en = 1'b0;
   int          m_pre = 0;
   logic [23:0] m_cnt = 24'h0;
   logic [15:0] m_shadow = 16'h0;
   logic        m_ack = 1'b0;
   logic [7:0]  m_rdata = 8'h0;
   logic        m_tick = 1'b0;
   logic [23:0] old_cnt;
   logic        old_en;
   int          off;

   minx_rtc_responder #(.TICKS_PER_SEC(TICKS), .ADDR_BASE(BASE)) dut (
      .clk_rt      (clk_rt),
      .reset       (reset),
      .rt_ce       (rt_ce),
      .req_toggle  (req_toggle),
      .req_write   (req_write),
      .req_address (req_address),
      .req_wdata   (req_wdata),
      .ack_toggle  (ack_toggle),
      .rdata       (rdata),
      .sec_count   (sec_count),
      .sec_tick    (sec_tick)
   );

   always #5 clk_rt = ~clk_rt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // A request flipped before edge 1 is executed on edge 4 and acknowledged on edge 5.
   always @(posedge clk_rt or posedge reset) begin
      if (reset) begin
         m_en = 1'b0; m_pre = 0; m_cnt = 24'h0; m_shadow = 16'h0;
         m_ack = 1'b0; m_rdata = 8'h0; m_tick = 1'b0;
         op_idx = n_issued;
         ack_edges.delete();
      end else begin
         edge_count++;
         if (f_seen != f_seq) begin
            m_cnt = f_cnt; m_pre = f_pre; f_seen = f_seq;
         end
         old_cnt = m_cnt;
         old_en  = m_en;
         m_tick  = 1'b0;
         if (m_en && rt_ce) begin
            if (m_pre == TICKS - 1) begin
               m_pre = 0; m_cnt = m_cnt + 24'd1; m_tick = 1'b1;
            end else begin
               m_pre = m_pre + 1;
            end
         end
         if (op_idx < n_issued && op_exec[op_idx] == edge_count) begin
            m_rdata = 8'h00;
            if (op_a[op_idx] >= BASE && op_a[op_idx] <= BASE + 24'd3) begin
               off = int'(op_a[op_idx] - BASE);
               if (op_w[op_idx]) begin
                  if (off == 0) begin
                     if (op_d[op_idx][1]) begin
                        m_pre = 0; m_cnt = 24'h0; m_tick = 1'b0;
                     end
                     m_en = op_d[op_idx][0];
                  end
               end else begin
                  case (off)
                     0: m_rdata = {7'd0, old_en};
                     1: begin m_rdata = old_cnt[7:0]; m_shadow = old_cnt[23:8]; end
                     2: m_rdata = m_shadow[7:0];
                     default: m_rdata = m_shadow[15:8];
                  endcase
               end
            end
            ack_edges.push_back(edge_count + 1);
            op_idx++;
         end
         if (ack_edges.size() > 0 && ack_edges[0] == edge_count) begin
            m_ack = ~m_ack;
            void'(ack_edges.pop_front());
         end
      end
   end

   always @(negedge clk_rt) begin
      if (!reset && run_cmp) begin
         check("ack_toggle", 32'(ack_toggle), 32'(m_ack));
         check("rdata", 32'(rdata), 32'(m_rdata));
         check("sec_count", 32'(sec_count), 32'(m_cnt));
         check("sec_tick", 32'(sec_tick), 32'(m_tick));
      end
   end

   task automatic step();
      @(negedge clk_rt);
      #2;
   endtask

   task automatic issue(input logic w, input logic [23:0] a, input logic [7:0] d);
      req_write   = w;
      req_address = a;
      req_wdata   = d;
      req_toggle  = ~req_toggle;
      op_exec[n_issued] = edge_count + 4;
      op_w[n_issued] = w;
      op_a[n_issued] = a;
      op_d[n_issued] = d;
      n_issued++;
   endtask

   task automatic finish_ack();
      repeat (4) step();
      check("ack_not_before_edge5", 32'(ack_toggle), 32'(exp_ack));
      step();
      exp_ack = ~exp_ack;
      check("ack_on_edge5", 32'(ack_toggle), 32'(exp_ack));
   endtask

   task automatic do_req(input logic w, input logic [23:0] a, input logic [7:0] d);
      issue(w, a, d);
      finish_ack();
   endtask

   task automatic force_state(input logic [23:0] cnt, input int pre);
      dut.seconds   = cnt;
      dut.prescaler = 15'(pre);
      f_cnt = cnt;
      f_pre = pre;
      f_seq++;
   endtask

   initial begin
      repeat (3) step();
      check("rst_ack", 32'(ack_toggle), 32'h0);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_sec_count", 32'(sec_count), 32'h0);
      check("rst_sec_tick", 32'(sec_tick), 32'h0);
      reset = 1'b0;
      run_cmp = 1'b1;

      // enable and first second
      do_req(1'b1, 24'h2008, 8'h01);
      check("count_before_second", 32'(sec_count), 32'h0);
      repeat (3) step();
      check("count_one", 32'(sec_count), 32'h1);
      check("tick_pulse", 32'(sec_tick), 32'h1);
      step();
      check("tick_one_cycle", 32'(sec_tick), 32'h0);
      do_req(1'b0, 24'h2008, 8'h00);
      check("ctrl_read_en", 32'(rdata), 32'h01);

      // coherent multi-byte read
      rt_ce = 1'b0;
      force_state(24'h1234FF, 3);
      do_req(1'b0, 24'h2009, 8'h00);
      check("cnt_l", 32'(rdata), 32'hFF);
      rt_ce = 1'b1;
      step();
      check("count_carry", 32'(sec_count), 32'h123500);
      do_req(1'b0, 24'h200A, 8'h00);
      check("cnt_m_shadow", 32'(rdata), 32'h34);
      do_req(1'b0, 24'h200B, 8'h00);
      check("cnt_h_shadow", 32'(rdata), 32'h12);

      // clear coincident with prescaler wrap
      force_state(24'h000010, 0);
      issue(1'b1, 24'h2008, 8'h03);
      repeat (4) step();
      check("clear_wins_count", 32'(sec_count), 32'h0);
      check("clear_wins_tick", 32'(sec_tick), 32'h0);
      step();
      exp_ack = ~exp_ack;
      check("clear_ack", 32'(ack_toggle), 32'(exp_ack));
      do_req(1'b0, 24'h2008, 8'h00);
      check("ctrl_after_clear", 32'(rdata), 32'h01);

      // 24-bit wrap then freeze
      force_state(24'hFFFFFF, 0);
      repeat (4) step();
      check("wrap_count", 32'(sec_count), 32'h0);
      check("wrap_tick", 32'(sec_tick), 32'h1);
      do_req(1'b1, 24'h2008, 8'h00);
      check("frozen_start", 32'(sec_count), 32'h1);
      repeat (20) step();
      check("frozen_after_20", 32'(sec_count), 32'h1);
      do_req(1'b0, 24'h2008, 8'h00);
      check("ctrl_disabled", 32'(rdata), 32'h00);

      // out-of-window write followed immediately by a read
      force_state(24'h0000A5, 2);
      issue(1'b1, 24'h2010, 8'hFF);
      repeat (5) step();
      exp_ack = ~exp_ack;
      check("oow_ack_edge5", 32'(ack_toggle), 32'(exp_ack));
      check("oow_rdata", 32'(rdata), 32'h00);
      do_req(1'b0, 24'h2009, 8'h00);
      check("b2b_read", 32'(rdata), 32'hA5);
      repeat (2) step();
      check("oow_no_side_effect", 32'(sec_count), 32'hA5);

      // reset while a write is in EXEC
      issue(1'b1, 24'h2008, 8'h01);
      repeat (3) step();
      check("state_exec", 32'(dut.state), 32'(S_EXEC));
      reset = 1'b1;
      req_toggle = 1'b0;
      exp_ack = 1'b0;
      #1;
      check("midrst_ack", 32'(ack_toggle), 32'h0);
      check("midrst_rdata", 32'(rdata), 32'h0);
      check("midrst_sec_count", 32'(sec_count), 32'h0);
      check("midrst_sec_tick", 32'(sec_tick), 32'h0);
      check("midrst_state", 32'(dut.state), 32'(S_IDLE));
      step();
      reset = 1'b0;
      repeat (10) step();
      check("no_phantom_ack", 32'(ack_toggle), 32'h0);
      check("no_enable_after_rst", 32'(sec_count), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
